dmem_port_arbiter: RTL and testbench

//  Two-master arbiter/sequencer for the byte-addressed data memory (HSEL2 slave).

---
 rtl/dmem_port_arbiter.sv | 158 +++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// Two-master round-robin arbiter/sequencer for the data memory (HSEL2 slave); 3-cycle IDLE/ACCESS/DONE sequence.
// Latency: gnt in the IDLE cycle, memory strobes in ACCESS, done/err/rdata in DONE. Backpressure: a losing req waits without gnt.
// Optional build macro DMEM_ARB_FIXED_PRIO_EN: master 0 always wins ties (master 1 may starve).
module dmem_port_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_BYTES = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_done,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_done,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_err,
    output logic              HSEL2,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] address_ram,
    output logic [DATA_W-1:0] write_data,
    input  logic [DATA_W-1:0] read_data
);
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_BYTES - 4);

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              owner_q, owner_d;
    logic              acc_err_q, acc_err_d;
    logic              hsel_q, hsel_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              done_q, done_d;
    logic              err_out_q, err_out_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              any_req;
    logic              win;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_err;

    assign any_req = m0_req | m1_req;

    // win: 0 selects master 0, 1 selects master 1
`ifdef DMEM_ARB_FIXED_PRIO_EN
    assign win = ~m0_req;
`else
    assign win = (m0_req & m1_req) ? ~last_grant_q : m1_req;
`endif

    assign sel_we    = win ? m1_we    : m0_we;
    assign sel_addr  = win ? m1_addr  : m0_addr;
    assign sel_wdata = win ? m1_wdata : m0_wdata;
    assign sel_err   = (sel_addr[1:0] != 2'b00) || (sel_addr > LAST_WORD);

    // Grant is presented in the IDLE cycle so the master may drop req right after the latching edge.
    assign m0_gnt = reset_n & (state_q == S_IDLE) & any_req & ~win;
    assign m1_gnt = reset_n & (state_q == S_IDLE) & any_req &  win;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        acc_err_d    = acc_err_q;
        hsel_d       = 1'b0;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        addr_d       = '0;
        wdata_d      = '0;
        done_d       = 1'b0;
        err_out_d    = 1'b0;
        rdata_d      = '0;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    state_d      = S_ACCESS;
                    last_grant_d = win;
                    owner_d      = win;
                    acc_err_d    = sel_err;
                    if (!sel_err) begin
                        hsel_d      = 1'b1;
                        mem_write_d = sel_we;
                        mem_read_d  = ~sel_we;
                        addr_d      = sel_addr;
                        wdata_d     = sel_we ? sel_wdata : '0;
                    end
                end
            end
            S_ACCESS: begin
                state_d   = S_DONE;
                done_d    = 1'b1;
                err_out_d = acc_err_q;
                rdata_d   = acc_err_q ? '0 : read_data;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            acc_err_q    <= 1'b0;
            hsel_q       <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            done_q       <= 1'b0;
            err_out_q    <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            acc_err_q    <= acc_err_d;
            hsel_q       <= hsel_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            done_q       <= done_d;
            err_out_q    <= err_out_d;
            rdata_q      <= rdata_d;
        end
    end

    assign HSEL2       = hsel_q;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign address_ram = addr_q;
    assign write_data  = wdata_q;

    assign m0_done  = done_q & ~owner_q;
    assign m1_done  = done_q &  owner_q;
    assign m0_err   = err_out_q & ~owner_q;
    assign m1_err   = err_out_q &  owner_q;
    assign m0_rdata = owner_q ? '0 : rdata_q;
    assign m1_rdata = owner_q ? rdata_q : '0;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a word-array memory model behind the HSEL2 port.
module tb_dmem_port_arbiter;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        HSEL2, mem_read, mem_write;
    logic [31:0] address_ram, write_data, read_data;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_BYTES(1024)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .HSEL2(HSEL2), .mem_read(mem_read), .mem_write(mem_write),
        .address_ram(address_ram), .write_data(write_data), .read_data(read_data)
    );

    logic [31:0] mem [0:255] = '{default: 32'h0};
    assign read_data = HSEL2 ? mem[address_ram[9:2]] : 32'h0;
    always @(posedge clk) if (HSEL2 && mem_write) mem[address_ram[9:2]] <= write_data;

    int tests_run = 0;
    int tests_failed = 0;

    // Leaves the bench at posedge+1 with reset asserted and all inputs idle.
    task automatic do_reset;
        reset_n = 1'b0;
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Issues one access from master m, drops req after gnt and scrambles its inputs.
    task automatic run_single(input bit m, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                              output logic [31:0] rd, output logic er, output int gnt_at, output int done_at,
                              output int act_cycles, output logic [31:0] acc_addr, output logic [31:0] acc_wd,
                              output logic acc_wr, output bit bad);
        logic g;
        gnt_at = -1; done_at = -1; rd = 0; er = 0; act_cycles = 0;
        acc_addr = 0; acc_wd = 0; acc_wr = 0; bad = 0;
        if (m) begin m1_req = 1; m1_we = we; m1_addr = addr; m1_wdata = wdata; end
        else   begin m0_req = 1; m0_we = we; m0_addr = addr; m0_wdata = wdata; end
        for (int c = 0; c < 12 && done_at < 0; c++) begin
            #1;
            g = m ? m1_gnt : m0_gnt;
            if (g && gnt_at < 0) gnt_at = c;
            if (HSEL2 || mem_read || mem_write) begin
                act_cycles++;
                acc_addr = address_ram; acc_wd = write_data; acc_wr = mem_write;
                if (!HSEL2 || (mem_read == mem_write)) bad = 1;
            end
            if (m ? (m0_gnt | m0_done | m0_err | (m0_rdata != 0))
                  : (m1_gnt | m1_done | m1_err | (m1_rdata != 0))) bad = 1;
            if (m ? m1_done : m0_done) begin
                done_at = c;
                rd = m ? m1_rdata : m0_rdata;
                er = m ? m1_err : m0_err;
            end
            @(posedge clk); #1;
            if (g) begin
                if (m) begin m1_req = 0; m1_we = ~we; m1_addr = 32'hFFFF_FFFF; m1_wdata = 32'hFFFF_FFFF; end
                else   begin m0_req = 0; m0_we = ~we; m0_addr = 32'hFFFF_FFFF; m0_wdata = 32'hFFFF_FFFF; end
            end
        end
    endtask

    task automatic test_reset;
        do_reset();
        tests_run++;
        if ({m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err, HSEL2, mem_read, mem_write} !== 9'h0 ||
            m0_rdata !== 0 || m1_rdata !== 0 || address_ram !== 0 || write_data !== 0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got ctl=%b addr=%h wd=%h expected all zero",
                     {m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err, HSEL2, mem_read, mem_write},
                     address_ram, write_data);
        end
        m0_req = 1; m1_req = 1;
        #1;
        tests_run++;
        if ({m0_gnt, m1_gnt} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_gnt: got %b expected 00", {m0_gnt, m1_gnt});
        end
        m0_req = 0; m1_req = 0;
        @(posedge clk); #1;
        reset_n = 1;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({m0_gnt, m1_gnt, m0_done, m1_done, HSEL2} !== 5'b0) begin
            tests_failed++;
            $display("FAIL idle_no_req: got %b expected 00000", {m0_gnt, m1_gnt, m0_done, m1_done, HSEL2});
        end
    endtask

    task automatic test_write_read;
        logic [31:0] rd, aa, awd; logic er, awr; int ga, da, act; bit bad;
        run_single(0, 1, 32'h10, 32'hDEADBEEF, rd, er, ga, da, act, aa, awd, awr, bad);
        tests_run++;
        if (ga !== 0 || da !== 2) begin
            tests_failed++;
            $display("FAIL wr_timing: got gnt=%0d done=%0d expected gnt=0 done=2", ga, da);
        end
        tests_run++;
        if (er !== 0 || act !== 1 || aa !== 32'h10 || awd !== 32'hDEADBEEF || awr !== 1 || bad) begin
            tests_failed++;
            $display("FAIL wr_access: got err=%b act=%0d addr=%h wd=%h we=%b bad=%b expected 0 1 00000010 deadbeef 1 0",
                     er, act, aa, awd, awr, bad);
        end
        run_single(0, 0, 32'h10, 32'h0, rd, er, ga, da, act, aa, awd, awr, bad);
        tests_run++;
        if (rd !== 32'hDEADBEEF || er !== 0 || da - ga !== 2) begin
            tests_failed++;
            $display("FAIL rd_data: got rdata=%h err=%b lat=%0d expected deadbeef 0 2", rd, er, da - ga);
        end
        tests_run++;
        if (act !== 1 || awr !== 0 || awd !== 0 || aa !== 32'h10 || bad) begin
            tests_failed++;
            $display("FAIL rd_access: got act=%0d we=%b wd=%h addr=%h bad=%b expected 1 0 0 00000010 0",
                     act, awr, awd, aa, bad);
        end
    endtask

    task automatic test_round_robin;
        logic [31:0] rd, aa, awd; logic er, awr; int ga, da, act; bit bad;
        logic e_g0, e_g1, e_d0, e_d1;
        do_reset(); reset_n = 1;
        run_single(0, 1, 32'h20, 32'h0BADF00D, rd, er, ga, da, act, aa, awd, awr, bad);
        do_reset();
        m0_req = 1; m0_addr = 32'h20; m1_req = 1; m1_addr = 32'h20;
        reset_n = 1;
        for (int c = 0; c < 12; c++) begin
            #1;
            e_g0 = (c % 3 == 0) && ((c / 3) % 2 == 0);
            e_g1 = (c % 3 == 0) && ((c / 3) % 2 == 1);
            e_d0 = (c % 3 == 2) && ((c / 3) % 2 == 0);
            e_d1 = (c % 3 == 2) && ((c / 3) % 2 == 1);
            tests_run++;
            if ({m0_gnt, m1_gnt, m0_done, m1_done} !== {e_g0, e_g1, e_d0, e_d1} ||
                (e_d0 && m0_rdata !== 32'h0BADF00D) || (e_d1 && m1_rdata !== 32'h0BADF00D)) begin
                tests_failed++;
                $display("FAIL rr_cycle%0d: got gnt/done=%b rd0=%h rd1=%h expected %b with rdata 0badf00d",
                         c, {m0_gnt, m1_gnt, m0_done, m1_done}, m0_rdata, m1_rdata, {e_g0, e_g1, e_d0, e_d1});
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_errors;
        logic [31:0] rd, aa, awd; logic er, awr; int ga, da, act; bit bad;
        logic [31:0] bad_addr [2];
        bad_addr[0] = 32'h3FE; bad_addr[1] = 32'h400;
        do_reset(); reset_n = 1;
        for (int i = 0; i < 2; i++) begin
            run_single(1, 0, bad_addr[i], 32'h0, rd, er, ga, da, act, aa, awd, awr, bad);
            tests_run++;
            if (er !== 1 || rd !== 0 || act !== 0 || bad || ga !== 0 || da !== 2) begin
                tests_failed++;
                $display("FAIL err_%h: got err=%b rdata=%h act=%0d bad=%b gnt=%0d done=%0d expected 1 0 0 0 0 2",
                         bad_addr[i], er, rd, act, bad, ga, da);
            end
        end
    endtask

    task automatic test_last_word;
        logic [31:0] rd, aa, awd; logic er, awr; int ga, da, act; bit bad;
        run_single(1, 1, 32'h3FC, 32'h12345678, rd, er, ga, da, act, aa, awd, awr, bad);
        tests_run++;
        if (er !== 0 || act !== 1 || awr !== 1 || mem[255] !== 32'h12345678 || bad) begin
            tests_failed++;
            $display("FAIL last_wr: got err=%b act=%0d we=%b mem=%h bad=%b expected 0 1 1 12345678 0",
                     er, act, awr, mem[255], bad);
        end
        run_single(1, 0, 32'h3FC, 32'h0, rd, er, ga, da, act, aa, awd, awr, bad);
        tests_run++;
        if (er !== 0 || rd !== 32'h12345678 || bad) begin
            tests_failed++;
            $display("FAIL last_rd: got err=%b rdata=%h bad=%b expected 0 12345678 0", er, rd, bad);
        end
    endtask

    task automatic test_reset_abort;
        do_reset(); reset_n = 1;
        m0_req = 1; m0_we = 1; m0_addr = 32'h40; m0_wdata = 32'hCAFEF00D;
        #1;
        @(posedge clk); #1;
        m0_req = 0;
        tests_run++;
        if ({HSEL2, mem_write, mem_read} !== 3'b110) begin
            tests_failed++;
            $display("FAIL abort_pre: got hsel/wr/rd=%b expected 110", {HSEL2, mem_write, mem_read});
        end
        #2; reset_n = 0; #1;
        tests_run++;
        if ({HSEL2, mem_write, mem_read} !== 3'b000 || address_ram !== 0 || write_data !== 0) begin
            tests_failed++;
            $display("FAIL abort_strobes: got %b addr=%h wd=%h expected 000 0 0",
                     {HSEL2, mem_write, mem_read}, address_ram, write_data);
        end
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (m0_done !== 0 || mem[16] !== 32'h0) begin
            tests_failed++;
            $display("FAIL abort_nodone: got done=%b mem=%h expected 0 00000000", m0_done, mem[16]);
        end
        m0_req = 1; m0_we = 0; m0_addr = 32'h40; m1_req = 1; m1_we = 0; m1_addr = 32'h44;
        reset_n = 1; #1;
        tests_run++;
        if ({m0_gnt, m1_gnt} !== 2'b10) begin
            tests_failed++;
            $display("FAIL abort_tie: got gnt=%b expected 10", {m0_gnt, m1_gnt});
        end
    endtask

    task automatic test_prio;
        logic exp_m1;
        do_reset();
        m0_req = 1; m0_addr = 32'h20; m1_req = 1; m1_addr = 32'h24;
        reset_n = 1;
        for (int k = 0; k < 4; k++) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
            exp_m1 = 1'b0;
`else
            exp_m1 = k[0];
`endif
            #1;
            tests_run++;
            if ({m0_gnt, m1_gnt} !== {~exp_m1, exp_m1}) begin
                tests_failed++;
                $display("FAIL prio_grant%0d: got %b expected %b", k, {m0_gnt, m1_gnt}, {~exp_m1, exp_m1});
            end
            repeat (3) begin @(posedge clk); #1; end
        end
        m0_req = 0; #1;
        tests_run++;
        if ({m0_gnt, m1_gnt} !== 2'b01) begin
            tests_failed++;
            $display("FAIL prio_m1_after_drop: got %b expected 01", {m0_gnt, m1_gnt});
        end
        @(posedge clk); #1;
        m1_req = 0;
        repeat (3) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_round_robin();
        test_errors();
        test_last_word();
        test_reset_abort();
        test_prio();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
